// File: rtl/dso_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package dso_pkg;

  localparam int unsigned DSO_AW   = 3;
  localparam int unsigned DSO_DW   = 8;
  localparam int unsigned DSO_NREG = 1 << DSO_AW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dso_state_e;

  // Fields latched from the winning requester
  typedef struct packed {
    logic              rw;
    logic [DSO_AW-1:0] addr;
    logic [DSO_DW-1:0] wdata;
  } dso_req_t;

endpackage

// File: rtl/dso_regarb_if.sv
// Requester handshakes plus the register-file port of the arbiter.
interface dso_regarb_if;
  import dso_pkg::*;

  logic              req0, req1;
  logic              rw0, rw1;
  logic [DSO_AW-1:0] addr0, addr1;
  logic [DSO_DW-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DSO_DW-1:0] rdata0, rdata1;
  logic              err0, err1;
  logic [DSO_AW-1:0] rf_addr;
  logic [DSO_DW-1:0] rf_din;
  logic              rf_we;
  logic [DSO_DW-1:0] rf_dout;
  logic              busy;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, rf_dout,
    output ack0, ack1, rdata0, rdata1, err0, err1, rf_addr, rf_din, rf_we, busy
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, rf_dout,
    input  ack0, ack1, rdata0, rdata1, err0, err1, rf_addr, rf_din, rf_we, busy
  );

endinterface

// File: rtl/dso_rrpick.sv
// Two-way round-robin pick; ptr names the last-granted requester.
module dso_rrpick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ~ptr : req[1];

endmodule

// File: rtl/dso_regarb.sv
// Arbitrates two requesters onto one register-file port; each access is a
// fixed IDLE -> ACCESS -> DONE sequence with write protection per address.
module dso_regarb
  import dso_pkg::*;
#(
  parameter logic [DSO_NREG-1:0] WP_MASK = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  dso_regarb_if.slave  bus
);

  dso_state_e            state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  idx_q, idx_d;
  logic                  rw_q, rw_d;
  logic                  blk_q, blk_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [DSO_AW-1:0]     addr_q, addr_d;
  logic [DSO_DW-1:0]     din_q, din_d;
  logic [1:0][DSO_DW-1:0] rdata_q, rdata_d;

  logic     gnt_valid, gnt_idx;
  dso_req_t sel;

  dso_rrpick u_pick (
    .req       ({bus.req1, bus.req0}),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel = gnt_idx ? {bus.rw1, bus.addr1, bus.wdata1}
                       : {bus.rw0, bus.addr0, bus.wdata0};

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    blk_d   = blk_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    we_d    = 1'b0;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ACCESS;
          idx_d   = gnt_idx;
          rw_d    = sel.rw;
          addr_d  = sel.addr;
          din_d   = sel.wdata;
          blk_d   = sel.rw & WP_MASK[sel.addr];
          we_d    = sel.rw & ~WP_MASK[sel.addr];
          busy_d  = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (!rw_q) rdata_d[idx_q] = bus.rf_dout;
        ack_d[idx_q] = 1'b1;
        err_d[idx_q] = blk_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = idx_q;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      idx_q   <= 1'b0;
      rw_q    <= 1'b0;
      blk_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      blk_q   <= blk_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset kills an in-flight write enable within the same cycle
  assign bus.rf_we   = we_q & ~rst;
  assign bus.rf_addr = addr_q;
  assign bus.rf_din  = din_q;
  assign bus.ack0    = ack_q[0];
  assign bus.ack1    = ack_q[1];
  assign bus.err0    = err_q[0];
  assign bus.err1    = err_q[1];
  assign bus.rdata0  = rdata_q[0];
  assign bus.rdata1  = rdata_q[1];
  assign bus.busy    = busy_q;

endmodule
